pipe_ctrl_unit: RTL and testbench

- Second-generation pipeline control unit for the 5-stage MIPS core.
- Decodes the ID-stage opcode and registers the control bundle into the ID/EX control register.
- Detects load-use hazards and inserts parametrised stall bubbles.
- Sequences IF/ID flushes for taken branches and jumps over a parametrised number of cycles. Sits between the IF/ID register and the ID/EX datapath register.

---
 rtl/pipe_ctrl_unit.sv | 195 +++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// ID-stage control: opcode decode, load-use stall and branch flush sequencing.
// Optional perf counters (stall_cnt/flush_cnt) enabled by CTRL_PERF_CNT_EN.
module pipe_ctrl_unit #(
  parameter int OP_W         = 6,
  parameter int RA_W         = 5,
  parameter int LU_STALL_CYC = 1,
  parameter int BR_FLUSH_CYC = 1,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic [RA_W-1:0] ifid_rs,
  input  logic [RA_W-1:0] ifid_rt,
  input  logic            br_taken,
  input  logic            stall_in,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            if_flush,
  output logic            idex_reg_dst,
  output logic            idex_alu_src,
  output logic            idex_mem_to_reg,
  output logic            idex_reg_write,
  output logic            idex_mem_read,
  output logic            idex_mem_write,
  output logic            idex_branch,
  output logic            idex_jump,
  output logic [1:0]      idex_alu_op,
  output logic [RA_W-1:0] idex_rt,
  output logic            idex_illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYC - 1);
  localparam logic [1:0] BR_INIT = 2'(BR_FLUSH_CYC - 1);

  state_t     state;
  logic [1:0] cnt;
  ctrl_t      dec;
  ctrl_t      idex;
  logic       uses_rt;
  logic       hazard;
  logic       redirect;

  always_comb begin
    dec = '0;
    case (op)
      OP_R:    begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      OP_LW:   begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
      end
      OP_SW:   begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ:  begin
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_J:    dec.jump = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  // Only R, sw and beq actually read rt as a source operand
  assign uses_rt  = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
  assign hazard   = idex.mem_read && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) ||
                     ((idex_rt == ifid_rt) && uses_rt));
  assign redirect = ((op == OP_BEQ) && br_taken) || (op == OP_J);

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    if_flush   = 1'b0;
    if (rst || stall_in) begin
      pc_write = 1'b0;
    end else if (state == STALL) begin
      pc_write = 1'b0;
    end else if (state == FLUSH) begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      if_flush   = 1'b1;
    end else if (hazard) begin
      pc_write = 1'b0;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      if_flush   = redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      idex    <= '0;
      idex_rt <= '0;
    end else if (!stall_in) begin
      idex_rt <= ifid_rt;
      case (state)
        RUN: begin
          if (hazard) begin
            idex <= '0;
            if (LU_STALL_CYC > 1) begin
              state <= STALL;
              cnt   <= LU_INIT;
            end
          end else begin
            idex <= dec;
            if (redirect && (BR_FLUSH_CYC > 1)) begin
              state <= FLUSH;
              cnt   <= BR_INIT;
            end
          end
        end
        default: begin
          idex <= '0;
          cnt  <= cnt - 2'd1;
          if (cnt == 2'd1) state <= RUN;
        end
      endcase
    end
  end

  assign idex_reg_dst    = idex.reg_dst;
  assign idex_alu_src    = idex.alu_src;
  assign idex_mem_to_reg = idex.mem_to_reg;
  assign idex_reg_write  = idex.reg_write;
  assign idex_mem_read   = idex.mem_read;
  assign idex_mem_write  = idex.mem_write;
  assign idex_branch     = idex.branch;
  assign idex_jump       = idex.jump;
  assign idex_alu_op     = idex.alu_op;
  assign idex_illegal    = idex.illegal;

`ifdef CTRL_PERF_CNT_EN
  logic stall_ev;

  assign stall_ev = !rst && !stall_in &&
                    ((state == STALL) || ((state == RUN) && hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (if_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit (LU_STALL_CYC=2, BR_FLUSH_CYC=3).
module tb_pipe_ctrl_unit;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       br_taken;
  logic       stall_in;
  logic       pc_write;
  logic       ifid_write;
  logic       if_flush;
  logic       idex_reg_dst;
  logic       idex_alu_src;
  logic       idex_mem_to_reg;
  logic       idex_reg_write;
  logic       idex_mem_read;
  logic       idex_mem_write;
  logic       idex_branch;
  logic       idex_jump;
  logic [1:0] idex_alu_op;
  logic [4:0] idex_rt;
  logic       idex_illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,jump,alu_op,illegal}
  localparam logic [10:0] C_NOP  = 11'b0;
  localparam logic [10:0] C_R    = {8'b1001_0000, 2'b10, 1'b0};
  localparam logic [10:0] C_LW   = {8'b0111_1000, 2'b00, 1'b0};
  localparam logic [10:0] C_SW   = {8'b0100_0100, 2'b00, 1'b0};
  localparam logic [10:0] C_BEQ  = {8'b0000_0010, 2'b01, 1'b0};
  localparam logic [10:0] C_ADDI = {8'b0101_0000, 2'b00, 1'b0};
  localparam logic [10:0] C_J    = {8'b0000_0001, 2'b00, 1'b0};
  localparam logic [10:0] C_ILL  = {8'b0000_0000, 2'b00, 1'b1};

  logic [10:0] ctl;
  assign ctl = {idex_reg_dst, idex_alu_src, idex_mem_to_reg, idex_reg_write,
                idex_mem_read, idex_mem_write, idex_branch, idex_jump,
                idex_alu_op, idex_illegal};

  logic [2:0] wr;
  assign wr = {pc_write, ifid_write, if_flush};

  pipe_ctrl_unit #(
    .OP_W(6), .RA_W(5), .LU_STALL_CYC(2), .BR_FLUSH_CYC(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .op(op), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .br_taken(br_taken), .stall_in(stall_in),
    .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .idex_reg_dst(idex_reg_dst), .idex_alu_src(idex_alu_src),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_branch(idex_branch), .idex_jump(idex_jump),
    .idex_alu_op(idex_alu_op), .idex_rt(idex_rt),
    .idex_illegal(idex_illegal)
`ifdef CTRL_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [4:0] rs,
                       input logic [4:0] rt, input logic bt);
    op = o; ifid_rs = rs; ifid_rt = rt; br_taken = bt;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0;
    drive(6'b100011, 5'd0, 5'd0, 1'b0);
    cyc(); cyc();
    chk("rst_ctl", 32'(ctl), 32'(C_NOP));
    chk("rst_rt", 32'(idex_rt), 32'd0);
    chk("rst_wr", 32'(wr), 32'b000);

    rst = 1'b0;
    drive(6'b000000, 5'd0, 5'd0, 1'b0);
    chk("run_wr", 32'(wr), 32'b110);
    cyc();
    chk("r_ctl", 32'(ctl), 32'(C_R));

    // load-use through rs
    drive(6'b100011, 5'd0, 5'd5, 1'b0);
    chk("lw_wr", 32'(wr), 32'b110);
    cyc();
    chk("lw_ctl", 32'(ctl), 32'(C_LW));
    chk("lw_rt", 32'(idex_rt), 32'd5);
    drive(6'b000000, 5'd5, 5'd0, 1'b0);
    chk("lu_haz_wr", 32'(wr), 32'b000);
    cyc();
    chk("lu_b1_ctl", 32'(ctl), 32'(C_NOP));
    chk("lu_stall_wr", 32'(wr), 32'b000);
    cyc();
    chk("lu_b2_ctl", 32'(ctl), 32'(C_NOP));
    chk("lu_rel_wr", 32'(wr), 32'b110);
    cyc();
    chk("lu_r_ctl", 32'(ctl), 32'(C_R));

    // lw to r0 never stalls
    drive(6'b100011, 5'd0, 5'd0, 1'b0);
    cyc();
    drive(6'b000000, 5'd0, 5'd0, 1'b0);
    chk("lu_r0_wr", 32'(wr), 32'b110);
    cyc();
    chk("lu_r0_ctl", 32'(ctl), 32'(C_R));

    // taken branch, 3 flush cycles
    drive(6'b000100, 5'd1, 5'd1, 1'b1);
    chk("br_f1", 32'(wr), 32'b111);
    cyc();
    chk("br_ctl", 32'(ctl), 32'(C_BEQ));
    drive(6'b000000, 5'd0, 5'd0, 1'b0);
    chk("br_f2", 32'(wr), 32'b111);
    cyc();
    chk("br_b1_ctl", 32'(ctl), 32'(C_NOP));
    chk("br_f3", 32'(wr), 32'b111);
    cyc();
    chk("br_b2_ctl", 32'(ctl), 32'(C_NOP));
    chk("br_done_wr", 32'(wr), 32'b110);
    cyc();
    chk("br_r_ctl", 32'(ctl), 32'(C_R));

    // not-taken beq
    drive(6'b000100, 5'd1, 5'd2, 1'b0);
    chk("bnt_wr", 32'(wr), 32'b110);
    cyc();
    chk("bnt_ctl", 32'(ctl), 32'(C_BEQ));

`ifdef CTRL_PERF_CNT_EN
    chk("perf_stall", 32'(stall_cnt), 32'd2);
    chk("perf_flush", 32'(flush_cnt), 32'd3);
`endif

    // hazard and jump together: stall first, then flush
    drive(6'b100011, 5'd0, 5'd7, 1'b0);
    cyc();
    drive(6'b000010, 5'd7, 5'd0, 1'b0);
    chk("hj_haz_wr", 32'(wr), 32'b000);
    cyc();
    chk("hj_b1_ctl", 32'(ctl), 32'(C_NOP));
    chk("hj_stall_wr", 32'(wr), 32'b000);
    cyc();
    chk("hj_redir_wr", 32'(wr), 32'b111);
    cyc();
    chk("hj_j_ctl", 32'(ctl), 32'(C_J));
    drive(6'b000000, 5'd0, 5'd0, 1'b0);
    cyc();
    chk("hj_f_cnt1_wr", 32'(wr), 32'b111);

    // freeze in FLUSH with cnt=1
    stall_in = 1'b1;
    drive(6'b000000, 5'd0, 5'd9, 1'b0);
    chk("frz_wr", 32'(wr), 32'b000);
    cyc(); cyc();
    chk("frz_rt", 32'(idex_rt), 32'd0);
    chk("frz_ctl", 32'(ctl), 32'(C_NOP));
    stall_in = 1'b0;
    drive(6'b000000, 5'd0, 5'd0, 1'b0);
    chk("frz_rel_wr", 32'(wr), 32'b111);
    cyc();
    chk("frz_done_wr", 32'(wr), 32'b110);
    cyc();
    chk("frz_r_ctl", 32'(ctl), 32'(C_R));

    // freeze holds a live bundle
    stall_in = 1'b1;
    drive(6'b101011, 5'd0, 5'd3, 1'b0);
    cyc();
    chk("hold_ctl", 32'(ctl), 32'(C_R));
    stall_in = 1'b0;
    #1;
    cyc();
    chk("sw_ctl", 32'(ctl), 32'(C_SW));
    chk("sw_rt", 32'(idex_rt), 32'd3);

    // reset in STALL aborts it
    drive(6'b100011, 5'd0, 5'd4, 1'b0);
    cyc();
    drive(6'b000000, 5'd4, 5'd0, 1'b0);
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_stall_wr", 32'(wr), 32'b000);
    cyc();
    rst = 1'b0;
    drive(6'b001000, 5'd4, 5'd2, 1'b0);
    chk("post_rst_wr", 32'(wr), 32'b110);
    cyc();
    chk("addi_ctl", 32'(ctl), 32'(C_ADDI));

    drive(6'b111111, 5'd0, 5'd0, 1'b0);
    cyc();
    chk("ill_ctl", 32'(ctl), 32'(C_ILL));
    drive(6'b000000, 5'd0, 5'd0, 1'b0);
    cyc();
    chk("ill_clr_ctl", 32'(ctl), 32'(C_R));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
